// File: rtl/reg_file_read_port_if.sv
// Bus bundle for reg_file_read_port: write port, read request handshake and
// response handshake. The register file side uses the slave modport.
interface reg_file_read_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  WR_EN;
  logic [ADDR_WIDTH-1:0] WR_ADDR;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  REQ_VALID;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic                  REQ_READY;
  logic                  RESP_VALID;
  logic [DATA_WIDTH-1:0] RESP_DATA;
  logic [ADDR_WIDTH-1:0] RESP_ADDR;
  logic                  RESP_ERR;
  logic                  RESP_READY;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, REQ_VALID, REQ_ADDR, RESP_READY,
    input  REQ_READY, RESP_VALID, RESP_DATA, RESP_ADDR, RESP_ERR
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, REQ_VALID, REQ_ADDR, RESP_READY,
    output REQ_READY, RESP_VALID, RESP_DATA, RESP_ADDR, RESP_ERR
  );
endinterface

// File: rtl/reg_file_read_port.sv
// Register file with one write port and a valid/ready read port feeding a
// 2-entry response queue. Register 0 reads as zero and ignores writes.
// Optional macro REG_FILE_WRITE_BYPASS_EN: a read accepted together with a
// write to the same in-range nonzero address returns the new write data.
//
// state | meaning
// EMPTY | no response queued
// ONE   | head entry valid
// FULL  | head and tail entries valid, requests stalled
module reg_file_read_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_COUNT  = 32
) (
  input logic              CLK,
  input logic              RST,
  reg_file_read_port_if.slave bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REG_COUNT);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] mem_d [REG_COUNT];
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d, tail_addr_q, tail_addr_d;
  logic                  head_err_q, head_err_d, tail_err_q, tail_err_d;

  logic                  wr_ok, req_err, req_ready, push, pop;
  logic [DATA_WIDTH-1:0] rd_data;

  assign wr_ok     = bus.WR_EN && (bus.WR_ADDR != '0) && ({1'b0, bus.WR_ADDR} < REG_LIMIT);
  assign req_err   = ({1'b0, bus.REQ_ADDR} >= REG_LIMIT);
  assign req_ready = (state_q != FULL);
  assign push      = bus.REQ_VALID && req_ready;
  assign pop       = (state_q != EMPTY) && bus.RESP_READY;

  // Read data for a request accepted this cycle (old contents unless forwarding)
  always_comb begin
    rd_data = '0;
    if (!req_err && bus.REQ_ADDR != '0) begin
      rd_data = mem_q[bus.REQ_ADDR];
`ifdef REG_FILE_WRITE_BYPASS_EN
      if (wr_ok && bus.WR_ADDR == bus.REQ_ADDR) begin
        rd_data = bus.WR_DATA;
      end
`endif
    end
  end

  // Storage update; entry 0 is never written so it stays at its reset zero
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[bus.WR_ADDR] = bus.WR_DATA;
    end
  end

  // Queue next-state and entry updates
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_addr_d = head_addr_q;
    head_err_d  = head_err_q;
    tail_data_d = tail_data_q;
    tail_addr_d = tail_addr_q;
    tail_err_d  = tail_err_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_data_d = rd_data;
          head_addr_d = bus.REQ_ADDR;
          head_err_d  = req_err;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_data_d = rd_data;
          head_addr_d = bus.REQ_ADDR;
          head_err_d  = req_err;
        end else if (push) begin
          tail_data_d = rd_data;
          tail_addr_d = bus.REQ_ADDR;
          tail_err_d  = req_err;
          state_d     = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_addr_d = tail_addr_q;
          head_err_d  = tail_err_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, queue entries and storage registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_addr_q <= '0;
      head_err_q  <= 1'b0;
      tail_data_q <= '0;
      tail_addr_q <= '0;
      tail_err_q  <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_addr_q <= head_addr_d;
      head_err_q  <= head_err_d;
      tail_data_q <= tail_data_d;
      tail_addr_q <= tail_addr_d;
      tail_err_q  <= tail_err_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.REQ_READY  = req_ready;
  assign bus.RESP_VALID = (state_q != EMPTY);
  assign bus.RESP_DATA  = head_data_q;
  assign bus.RESP_ADDR  = head_addr_q;
  assign bus.RESP_ERR   = head_err_q;

endmodule

// File: tb/tb_reg_file_read_port.sv
// Testbench for reg_file_read_port (REG_COUNT=20) with a response scoreboard.
module tb_reg_file_read_port;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RC = 20;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          err;
  } resp_t;

  resp_t         sb[$];
  logic [DW-1:0] model_mem [RC];

  reg_file_read_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file_read_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled at negedge, inputs only change just after posedge
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      for (int i = 0; i < RC; i++) model_mem[i] = '0;
    end else begin
      if (bus.RESP_VALID && bus.RESP_READY) begin
        chk("sb_nonempty", DW'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          resp_t e;
          e = sb.pop_front();
          chk("resp_data", bus.RESP_DATA, e.data);
          chk("resp_addr", DW'(bus.RESP_ADDR), DW'(e.addr));
          chk("resp_err", DW'(bus.RESP_ERR), DW'(e.err));
        end
      end
      if (bus.REQ_VALID && bus.REQ_READY) begin
        resp_t n;
        n.addr = bus.REQ_ADDR;
        n.err  = (int'(bus.REQ_ADDR) >= RC);
        n.data = '0;
        if (!n.err && bus.REQ_ADDR != 0) begin
          n.data = model_mem[bus.REQ_ADDR];
`ifdef REG_FILE_WRITE_BYPASS_EN
          if (bus.WR_EN && bus.WR_ADDR == bus.REQ_ADDR) n.data = bus.WR_DATA;
`endif
        end
        sb.push_back(n);
      end
      if (bus.WR_EN && bus.WR_ADDR != 0 && int'(bus.WR_ADDR) < RC) begin
        model_mem[bus.WR_ADDR] = bus.WR_DATA;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.WR_EN = 1'b1;
    bus.WR_ADDR = a;
    bus.WR_DATA = d;
    cyc();
    bus.WR_EN = 1'b0;
  endtask

  task automatic send(input logic [AW-1:0] a);
    logic ok, rdy;
    ok = 1'b0;
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR = a;
    for (int i = 0; i < 20; i++) begin
      rdy = bus.REQ_READY;
      cyc();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.REQ_VALID = 1'b0;
    chk("accept", DW'(ok), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && bus.RESP_VALID; i++) cyc();
    chk("drained", DW'(bus.RESP_VALID), 0);
    chk("sb_empty", DW'(sb.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.WR_EN = 1'b0;
    bus.WR_ADDR = '0;
    bus.WR_DATA = '0;
    bus.REQ_VALID = 1'b0;
    bus.REQ_ADDR = '0;
    bus.RESP_READY = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_req_ready", DW'(bus.REQ_READY), 1);
    chk("rst_resp_valid", DW'(bus.RESP_VALID), 0);
    chk("rst_resp_data", bus.RESP_DATA, 0);
    chk("rst_resp_addr", DW'(bus.RESP_ADDR), 0);
    chk("rst_resp_err", DW'(bus.RESP_ERR), 0);

    wr(1, 9);
    wr(2, 13);
    wr(4, 24);
    wr(3, 24);
    wr(7, 24);
    wr(5, 77);
    wr(0, 13);
    wr(25, 55);

    // Latency and echo for r3
    bus.RESP_READY = 1'b1;
    send(3);
    chk("lat_valid", DW'(bus.RESP_VALID), 1);
    chk("lat_data", bus.RESP_DATA, 24);
    chk("lat_addr", DW'(bus.RESP_ADDR), 3);
    chk("lat_err", DW'(bus.RESP_ERR), 0);

    send(0);
    chk("r0_data", bus.RESP_DATA, 0);

    send(25);
    chk("oor_err", DW'(bus.RESP_ERR), 1);
    chk("oor_data", bus.RESP_DATA, 0);
    chk("oor_addr", DW'(bus.RESP_ADDR), 25);
    drain();

    // Back-pressure: two accepts then stall
    bus.RESP_READY = 1'b0;
    send(1);
    send(2);
    chk("bp_ready_low", DW'(bus.REQ_READY), 0);
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR = 4;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_stall_ready", DW'(bus.REQ_READY), 0);
      chk("bp_stable_data", bus.RESP_DATA, 9);
      chk("bp_stable_valid", DW'(bus.RESP_VALID), 1);
    end
    bus.RESP_READY = 1'b1;
    cyc();
    chk("bp_second", bus.RESP_DATA, 13);
    send(4);
    chk("bp_third", bus.RESP_DATA, 24);
    drain();

    // Full throughput
    for (int i = 1; i <= 6; i++) begin
      bus.REQ_VALID = 1'b1;
      bus.REQ_ADDR = AW'(i);
      chk("tp_ready", DW'(bus.REQ_READY), 1);
      cyc();
    end
    bus.REQ_VALID = 1'b0;
    drain();

    // Same-cycle write and read of r7
    bus.WR_EN = 1'b1;
    bus.WR_ADDR = 7;
    bus.WR_DATA = 9;
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR = 7;
    cyc();
    bus.WR_EN = 1'b0;
    bus.REQ_VALID = 1'b0;
`ifdef REG_FILE_WRITE_BYPASS_EN
    chk("same_cycle", bus.RESP_DATA, 9);
`else
    chk("same_cycle", bus.RESP_DATA, 24);
`endif
    send(7);
    chk("after_write", bus.RESP_DATA, 9);
    drain();

    // Reset with two responses queued
    bus.RESP_READY = 1'b0;
    send(5);
    send(3);
    chk("pre_rst_full", DW'(bus.REQ_READY), 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_valid", DW'(bus.RESP_VALID), 0);
    chk("mid_rst_ready", DW'(bus.REQ_READY), 1);
    bus.RESP_READY = 1'b1;
    send(5);
    chk("post_rst_r5", bus.RESP_DATA, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_read_port.md
Name: reg_file_read_port

Overview:
- Register file with one write port and one handshaked read port: the read-side counterpart to the 32-bit load/reset register.
- Holds REG_COUNT words of DATA_WIDTH bits.
- Read requests are accepted over a valid/ready handshake. Results return through a 2-entry response queue, which allows one read per cycle at full throughput.
- Sits between the register bank and the datapath/control unit that fetches operands.

Parameters:
- DATA_WIDTH, 32, width of each stored word and of RESP_DATA.
- ADDR_WIDTH, 5, width of WR_ADDR, REQ_ADDR and RESP_ADDR.
- REG_COUNT, 32, number of implemented registers. Legal range 2..2^ADDR_WIDTH.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset; synchronous, active-high.
- WR_EN  input  1  write strobe.
- WR_ADDR  input  ADDR_WIDTH  write address.
- WR_DATA  input  DATA_WIDTH  write data.
- REQ_VALID  input  1  read request present.
- REQ_ADDR  input  ADDR_WIDTH  read address.
- REQ_READY  output  1  port can accept a request this cycle.
- RESP_VALID  output  1  response queue head valid.
- RESP_DATA  output  DATA_WIDTH  head read data.
- RESP_ADDR  output  ADDR_WIDTH  head address echo.
- RESP_ERR  output  1  head address was out of range.
- RESP_READY  input  1  consumer takes head this cycle.

Behaviour:
- Reset is synchronous and active-high. A rising edge with RST=1 clears all storage words to 0 and flushes the queue (count=0).
- After reset: REQ_READY=1, RESP_VALID=0, RESP_DATA=0, RESP_ADDR=0, RESP_ERR=0.
- RST overrides any write, request or pop in the same cycle. A response in flight is discarded.
- Register 0 is hardwired to zero:
  - A write to address 0 is ignored.
  - A read of address 0 returns 0.
- Write:
  - Storage[WR_ADDR] <= WR_DATA at an edge where WR_EN=1 and 0 < WR_ADDR < REG_COUNT.
  - A write to WR_ADDR >= REG_COUNT is silently dropped.
- Request accept: a request is accepted when REQ_VALID & REQ_READY at the edge.
- REQ_READY is 1 when count < 2.
  - It is a function of registered state only, with no combinational path from RESP_READY.
- Read timing:
  - The accepted entry captures storage[REQ_ADDR] as it was before any write at the same edge (read-before-write). See WRITE_BYPASS_EN for the alternative.
  - The entry also captures REQ_ADDR and ERR = (REQ_ADDR >= REG_COUNT).
  - When ERR=1, data=0.
- Latency: a request accepted at edge N gives RESP_VALID=1 from edge N, observable in cycle N+1, provided the queue was empty.
- Pop: the head is removed when RESP_VALID & RESP_READY at the edge.
- Ordering: responses leave in request order.
- The RESP_* outputs are registered queue-head values. They hold stable while RESP_VALID=1 and RESP_READY=0.
- Queue FSM states are EMPTY, ONE and FULL:
  - EMPTY: a push goes to ONE; otherwise stay.
  - ONE: push without pop goes to FULL; pop without push goes to EMPTY; push with pop stays in ONE, and the new entry becomes head at the next edge.
  - FULL: a pop goes to ONE. A push is impossible because REQ_READY=0.
- RESP_VALID = (state != EMPTY).
- Throughput: with RESP_READY held 1, one request per cycle is sustained indefinitely.
- No illegal state is reachable. Any unencoded state returns to EMPTY.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined:
  - If a request is accepted at the same edge as a valid write with WR_ADDR == REQ_ADDR != 0, the entry captures WR_DATA (write-first forwarding).
  - Writes to address 0 or to out-of-range addresses never forward.
- Undefined: read-before-write as stated above. The old value is returned and the new value is visible to the next request.

Test Plan:
- Reset, then reset again mid-stream with 2 responses queued: after the edge with RST=1, RESP_VALID=0, REQ_READY=1. A subsequent read of address 5 returns 0.
- Write 24 to r3, then read r3 with RESP_READY=1: RESP_VALID=1 one cycle after accept, RESP_DATA=24, RESP_ADDR=3, RESP_ERR=0.
- Write 13 to r0, then read r0: RESP_DATA=0.
- REG_COUNT=20, read address 25: RESP_ERR=1, RESP_DATA=0.
- Back-pressure:
  - Hold RESP_READY=0 and issue reads of r1, r2 and r4 (preloaded 9, 13, 24). REQ_READY drops after 2 accepts and the third request stalls.
  - Raise RESP_READY: data emerges in order 9, 13, 24.
  - RESP_DATA stays stable while stalled.
- Same-cycle write 9 and read of r7 (old value 24):
  - Without REG_FILE_WRITE_BYPASS_EN: RESP_DATA=24, and the next read returns 9.
  - With the macro: RESP_DATA=9.
